// File: rtl/scalar_pkg.sv
// Shared definitions for the scalar-product datapath.
// Holds size defaults, the loader state enum and the lane-offset helper.
package scalar_pkg;

    localparam int SIZE_ARRAY_DEF = 256;
    localparam int SIZE_INT_DEF   = 32;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    function automatic int lane_off(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/scalar_lane_decoder.sv
// Lane write-enable decoder: idx -> one-hot of N lanes, gated by en.
// Ports: idx_i lane index, en_i write enable, onehot_o per-lane enables.
module scalar_lane_decoder #(
    parameter int N = 256
) (
    input  logic [$clog2(N)-1:0] idx_i,
    input  logic                 en_i,
    output logic [N-1:0]         onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/scalar_vector_loader.sv
// Packs a valid/ready stream of (x, y) pairs into flat IX/IY vectors.
// Ports: clk/rst_n/clear, in_* element stream, IX/IY/vec_* vector out, fill_count.
module scalar_vector_loader
    import scalar_pkg::*;
#(
    parameter int SIZE_ARRAY = SIZE_ARRAY_DEF,
    parameter int SIZE_INT   = SIZE_INT_DEF,
    parameter int SIZE       = SIZE_ARRAY * SIZE_INT
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SIZE_INT-1:0]             in_x,
    input  logic [SIZE_INT-1:0]             in_y,
    output logic [SIZE-1:0]                 IX,
    output logic [SIZE-1:0]                 IY,
    output logic                            vec_valid,
    input  logic                            vec_ack,
    output logic [$clog2(SIZE_ARRAY+1)-1:0] fill_count
);

    localparam int IW = $clog2(SIZE_ARRAY);
    localparam int CW = $clog2(SIZE_ARRAY + 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] ix_q, iy_q;

    logic                  accept;
    logic                  wr_en;
    logic [SIZE_ARRAY-1:0] lane_we;

    assign accept = in_valid & (state_q == FILL);
    // Clear wins over a same-cycle accept: the element is dropped.
    assign wr_en  = accept & ~clear;

    scalar_lane_decoder #(
        .N(SIZE_ARRAY)
    ) u_dec (
        .idx_i   (idx_q),
        .en_i    (wr_en),
        .onehot_o(lane_we)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = FILL;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (accept) begin
                        cnt_d = cnt_q + CW'(1);
                        if (idx_q == IW'(SIZE_ARRAY - 1)) begin
                            state_d = FULL;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
                FULL: begin
                    if (vec_ack) begin
                        state_d = FILL;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lanes keep old data until rewritten; only reset zeroes them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ix_q <= '0;
            iy_q <= '0;
        end else begin
            for (int i = 0; i < SIZE_ARRAY; i++) begin
                if (lane_we[i]) begin
                    ix_q[lane_off(i, SIZE_INT) +: SIZE_INT] <= in_x;
                    iy_q[lane_off(i, SIZE_INT) +: SIZE_INT] <= in_y;
                end
            end
        end
    end

    assign in_ready   = (state_q == FILL);
    assign vec_valid  = (state_q == FULL);
    assign fill_count = cnt_q;
    assign IX         = ix_q;
    assign IY         = iy_q;

endmodule

// File: tb/tb_scalar_vector_loader.sv
// Scoreboard bench for scalar_vector_loader.
// Drives a 256x32 instance and a 4x8 instance from one clock.
module tb_scalar_vector_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Large instance
    logic        b_clear = 1'b0, b_in_valid = 1'b0, b_vec_ack = 1'b0;
    logic        b_in_ready, b_vec_valid;
    logic [31:0] b_in_x = '0, b_in_y = '0;
    logic [8191:0] b_IX, b_IY;
    logic [8:0]  b_fill;

    // Small instance
    logic        s_clear = 1'b0, s_in_valid = 1'b0, s_vec_ack = 1'b0;
    logic        s_in_ready, s_vec_valid;
    logic [7:0]  s_in_x = '0, s_in_y = '0;
    logic [31:0] s_IX, s_IY;
    logic [2:0]  s_fill;

    logic [31:0] bqx[$], bqy[$];
    logic [7:0]  sqx[$], sqy[$];

    scalar_vector_loader u_big (
        .clk(clk), .rst_n(rst_n), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_x(b_in_x), .in_y(b_in_y),
        .IX(b_IX), .IY(b_IY),
        .vec_valid(b_vec_valid), .vec_ack(b_vec_ack),
        .fill_count(b_fill)
    );

    scalar_vector_loader #(.SIZE_ARRAY(4), .SIZE_INT(8)) u_small (
        .clk(clk), .rst_n(rst_n), .clear(s_clear),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_x(s_in_x), .in_y(s_in_y),
        .IX(s_IX), .IY(s_IY),
        .vec_valid(s_vec_valid), .vec_ack(s_vec_ack),
        .fill_count(s_fill)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        nvec++;
        if (b_in_ready !== 1'b1 || b_vec_valid !== 1'b0 || b_fill !== 9'd0) begin
            nerr++;
            $display("FAIL reset_big_ctl: rdy=%b vv=%b fc=%0d want 1 0 0",
                     b_in_ready, b_vec_valid, b_fill);
        end
        nvec++;
        if (b_IX !== '0 || b_IY !== '0) begin
            nerr++;
            $display("FAIL reset_big_vec: IX/IY nonzero, want 0");
        end
        nvec++;
        if (s_in_ready !== 1'b1 || s_vec_valid !== 1'b0 || s_fill !== 3'd0 ||
            s_IX !== 32'h0 || s_IY !== 32'h0) begin
            nerr++;
            $display("FAIL reset_small: rdy=%b vv=%b fc=%0d IX=%h IY=%h want 1 0 0 0 0",
                     s_in_ready, s_vec_valid, s_fill, s_IX, s_IY);
        end
    endtask

    task automatic test_big_fill();
        int n = 0;
        int cyc = 0;
        bit early = 0;
        logic [31:0] ex, ey;
        while (n < 256 && cyc < 600) begin
            b_in_valid = 1'b1;
            b_in_x = 32'(n);
            b_in_y = 32'(2 * n);
            if (b_vec_valid) early = 1;
            if (b_in_ready) begin
                bqx.push_back(b_in_x);
                bqy.push_back(b_in_y);
                n++;
            end
            step();
            cyc++;
        end
        b_in_valid = 1'b0;
        nvec++;
        if (n != 256 || early) begin
            nerr++;
            $display("FAIL big_fill_progress: accepts=%0d early_vv=%0d want 256 0", n, early);
        end
        nvec++;
        if (b_vec_valid !== 1'b1 || b_in_ready !== 1'b0 || b_fill !== 9'd256) begin
            nerr++;
            $display("FAIL big_full_ctl: vv=%b rdy=%b fc=%0d want 1 0 256",
                     b_vec_valid, b_in_ready, b_fill);
        end
        for (int i = 0; i < 256; i++) begin
            ex = (bqx.size() > 0) ? bqx.pop_front() : 32'hDEAD_BEEF;
            ey = (bqy.size() > 0) ? bqy.pop_front() : 32'hDEAD_BEEF;
            nvec++;
            if (b_IX[i*32 +: 32] !== ex || b_IY[i*32 +: 32] !== ey) begin
                nerr++;
                $display("FAIL big_lane%0d: x=%h y=%h want %h %h",
                         i, b_IX[i*32 +: 32], b_IY[i*32 +: 32], ex, ey);
            end
        end
        b_vec_ack = 1'b1;
        step();
        b_vec_ack = 1'b0;
        nvec++;
        if (b_vec_valid !== 1'b0 || b_in_ready !== 1'b1 || b_fill !== 9'd0) begin
            nerr++;
            $display("FAIL big_ack: vv=%b rdy=%b fc=%0d want 0 1 0",
                     b_vec_valid, b_in_ready, b_fill);
        end
    endtask

    task automatic small_load(input string nm, input logic [31:0] xv,
                              input logic [31:0] yv, input bit gaps);
        int n = 0;
        int cyc = 0;
        bit early = 0;
        logic [31:0] ex = '0, ey = '0;
        while (n < 4 && cyc < 200) begin
            s_in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            s_in_x = xv[n*8 +: 8];
            s_in_y = yv[n*8 +: 8];
            if (s_vec_valid) early = 1;
            if (s_in_valid && s_in_ready) begin
                sqx.push_back(s_in_x);
                sqy.push_back(s_in_y);
                n++;
            end
            step();
            cyc++;
        end
        s_in_valid = 1'b0;
        nvec++;
        if (n != 4 || early) begin
            nerr++;
            $display("FAIL %s_progress: accepts=%0d early_vv=%0d want 4 0", nm, n, early);
        end
        nvec++;
        if (s_vec_valid !== 1'b1 || s_in_ready !== 1'b0 || s_fill !== 3'd4) begin
            nerr++;
            $display("FAIL %s_ctl: vv=%b rdy=%b fc=%0d want 1 0 4",
                     nm, s_vec_valid, s_in_ready, s_fill);
        end
        for (int i = 0; i < 4; i++) begin
            ex[i*8 +: 8] = (sqx.size() > 0) ? sqx.pop_front() : 8'hEE;
            ey[i*8 +: 8] = (sqy.size() > 0) ? sqy.pop_front() : 8'hEE;
        end
        nvec++;
        if (s_IX !== ex || s_IY !== ey) begin
            nerr++;
            $display("FAIL %s_vec: IX=%h IY=%h want %h %h", nm, s_IX, s_IY, ex, ey);
        end
    endtask

    task automatic test_gaps();
        small_load("gaps", 32'h44332211, 32'h88776655, 1'b1);
        nvec++;
        if (s_IX !== 32'h44332211) begin
            nerr++;
            $display("FAIL gaps_const: IX=%h want 44332211", s_IX);
        end
    endtask

    task automatic test_hold();
        logic [31:0] hx, hy;
        bit bad = 0;
        hx = s_IX;
        hy = s_IY;
        for (int i = 0; i < 10; i++) begin
            s_in_valid = 1'b1;
            s_in_x = 8'hFF;
            s_in_y = 8'hFF;
            s_vec_ack = 1'b0;
            step();
            if (s_IX !== 32'h44332211 || s_IY !== 32'h88776655 ||
                s_in_ready !== 1'b0 || s_vec_valid !== 1'b1 || s_fill !== 3'd4) bad = 1;
        end
        nvec++;
        if (bad || s_IX !== hx || s_IY !== hy) begin
            nerr++;
            $display("FAIL hold: IX=%h IY=%h rdy=%b want 44332211 88776655 0",
                     s_IX, s_IY, s_in_ready);
        end
        s_in_valid = 1'b0;
        s_vec_ack = 1'b1;
        step();
        s_vec_ack = 1'b0;
        nvec++;
        if (s_vec_valid !== 1'b0 || s_in_ready !== 1'b1 || s_fill !== 3'd0) begin
            nerr++;
            $display("FAIL hold_ack: vv=%b rdy=%b fc=%0d want 0 1 0",
                     s_vec_valid, s_in_ready, s_fill);
        end
        nvec++;
        if (s_IX !== 32'h44332211) begin
            nerr++;
            $display("FAIL ack_keeps_lanes: IX=%h want 44332211", s_IX);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 2; i++) begin
            s_in_valid = 1'b1;
            s_in_x = 8'(8'h05 + i);
            s_in_y = 8'(8'h0A + i);
            step();
        end
        nvec++;
        if (s_fill !== 3'd2) begin
            nerr++;
            $display("FAIL clear_pre: fc=%0d want 2", s_fill);
        end
        s_clear = 1'b1;
        s_in_x = 8'h99;
        s_in_y = 8'h99;
        step();
        s_clear = 1'b0;
        s_in_valid = 1'b0;
        nvec++;
        if (s_fill !== 3'd0 || s_in_ready !== 1'b1 || s_vec_valid !== 1'b0) begin
            nerr++;
            $display("FAIL clear_ctl: fc=%0d rdy=%b vv=%b want 0 1 0",
                     s_fill, s_in_ready, s_vec_valid);
        end
        nvec++;
        if (s_IX !== 32'h44330605) begin
            nerr++;
            $display("FAIL clear_drop: IX=%h want 44330605", s_IX);
        end
        small_load("after_clear", 32'h04030201, 32'h40302010, 1'b0);
        nvec++;
        if (s_IX !== 32'h04030201) begin
            nerr++;
            $display("FAIL after_clear_const: IX=%h want 04030201", s_IX);
        end
    endtask

    task automatic test_reset_full();
        rst_n = 1'b0;
        s_vec_ack = 1'b1;
        step();
        rst_n = 1'b1;
        s_vec_ack = 1'b0;
        nvec++;
        if (s_vec_valid !== 1'b0 || s_in_ready !== 1'b1 ||
            s_IX !== 32'h0 || s_IY !== 32'h0 || s_fill !== 3'd0) begin
            nerr++;
            $display("FAIL reset_full: vv=%b rdy=%b IX=%h IY=%h fc=%0d want 0 1 0 0 0",
                     s_vec_valid, s_in_ready, s_IX, s_IY, s_fill);
        end
        s_in_valid = 1'b1;
        s_in_x = 8'h5A;
        s_in_y = 8'hA5;
        step();
        s_in_valid = 1'b0;
        s_vec_ack = 1'b1;
        step();
        step();
        s_vec_ack = 1'b0;
        nvec++;
        if (s_fill !== 3'd1 || s_in_ready !== 1'b1 || s_vec_valid !== 1'b0) begin
            nerr++;
            $display("FAIL stray_ack: fc=%0d rdy=%b vv=%b want 1 1 0",
                     s_fill, s_in_ready, s_vec_valid);
        end
        nvec++;
        if (s_IX !== 32'h0000005A || s_IY !== 32'h000000A5) begin
            nerr++;
            $display("FAIL stray_ack_vec: IX=%h IY=%h want 0000005a 000000a5", s_IX, s_IY);
        end
    endtask

    initial begin
        test_reset();
        test_big_fill();
        test_gaps();
        test_hold();
        test_clear();
        test_reset_full();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/scalar_vector_loader.md
Name: scalar_vector_loader

Overview:
Upstream feeder for the scalar-product datapath. Accepts one (x, y) element pair per cycle over a valid/ready stream and packs the pairs into two flat SIZE_ARRAY*SIZE_INT-bit vectors. Once all SIZE_ARRAY pairs are loaded, it presents IX/IY with vec_valid. It holds the vectors stable until the consumer acknowledges, then refills.

Parameters:
SIZE_ARRAY, 256, number of elements per vector; must be >= 2
SIZE_INT, 32, width of one element in bits
SIZE, SIZE_ARRAY*SIZE_INT, flat vector width (derived; do not override)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  synchronous, active-low reset
clear  input  1  synchronous abort of the current load
in_valid  input  1  element pair present on in_x/in_y
in_ready  output  1  loader can accept an element this cycle
in_x  input  SIZE_INT  X element
in_y  input  SIZE_INT  Y element
IX  output  SIZE  packed X vector; element i at bits [i*SIZE_INT +: SIZE_INT]
IY  output  SIZE  packed Y vector; same lane layout as IX
vec_valid  output  1  IX/IY hold a complete vector
vec_ack  input  1  consumer has taken the vector
fill_count  output  $clog2(SIZE_ARRAY+1)  number of elements loaded into the current vector

Behaviour:
- Reset (rst_n=0 at a clk edge): state=FILL, idx=0, fill_count=0, IX=0, IY=0, vec_valid=0. in_ready=1 from the first cycle after reset.
- All outputs are registered or decoded from registered state. in_ready = (state==FILL). No combinational path from inputs to outputs.
- States:
  - FILL: accept occurs when in_valid & in_ready. On accept, in_x goes to IX lane idx and in_y to IY lane idx, and idx and fill_count each increment by 1. An accept with idx==SIZE_ARRAY-1 moves the state to FULL, and vec_valid=1 in the next cycle. Latency is 1 cycle from the last accept to vec_valid.
  - FULL: in_ready=0, vec_valid=1, and IX/IY/fill_count=SIZE_ARRAY stay frozen. On vec_ack=1 the next cycle has state=FILL, idx=0, fill_count=0, vec_valid=0 and in_ready=1. IX/IY keep their old contents until overwritten lane by lane.
- vec_ack while vec_valid=0 is ignored.
- in_valid while in_ready=0 is ignored. The producer holds data until in_ready is high (standard valid/ready rules; in_valid must not depend on in_ready).
- Element order: the first accepted pair goes to lane 0 (LSBs) and the last to lane SIZE_ARRAY-1 (MSBs).
- clear=1 in any state: next cycle has state=FILL, idx=0, fill_count=0, vec_valid=0. Clear has priority over a simultaneous accept (the element is dropped) and over vec_ack. IX/IY are not modified by clear.
- rst_n has priority over clear. Reset mid-fill discards the partial vector and zeroes IX/IY.
- No back-to-back overlap: the first element of the next vector is accepted no earlier than the cycle after vec_ack. Peak throughput is SIZE_ARRAY+1 cycles per vector.
- idx width is $clog2(SIZE_ARRAY). The idx wrap is explicit (reset to 0 on entering FILL), never arithmetic overflow.

Decomposition:
- Shared package scalar_pkg:
  - SIZE_ARRAY/SIZE_INT defaults
  - state enum {FILL, FULL}
  - lane-offset constant function (i*SIZE_INT), shared with the scalar-product stage
- Single module. The lane write-enable decoder (idx -> one-hot of SIZE_ARRAY) is the natural sub-module, scalar_lane_decoder, reused by any other packing stage.

Test Plan:
- Reset, then 256 pairs x=i, y=2*i with in_valid held high -> in_ready drops and vec_valid=1 exactly 1 cycle after the 256th accept. IX lane i = i, IY lane i = 2*i, fill_count=256.
- SIZE_ARRAY=4, SIZE_INT=8, inputs x=0x11,0x22,0x33,0x44 with random in_valid gaps -> IX=0x44332211 with vec_valid asserted only after the 4th accept.
- Hold vec_ack=0 for 10 cycles in FULL while driving in_valid=1 with x=0xFF -> IX/IY unchanged and in_ready=0 throughout. After vec_ack: vec_valid=0, in_ready=1, fill_count=0 next cycle.
- SIZE_ARRAY=4: 2 accepts, then clear together with in_valid=1 (x=0x99) -> element dropped and fill_count=0. The next 4 pairs 1,2,3,4 yield IX=0x04030201.
- rst_n=0 during FULL with vec_ack=1 -> next cycle vec_valid=0, IX=IY=0, in_ready=1. Stray vec_ack in FILL has no effect on fill_count.
